frame_buf_roi_rd_sched: RTL and testbench

//   Read-side scheduler for the multi-ROI frame buffer back buffer. When a complete

---
 rtl/frame_buf_roi_rd_sched_if.sv | 28 ++
 rtl/frame_buf_roi_rd_sched.sv | 217 +++++++++++++++++++++
 tb/tb_frame_buf_roi_rd_sched.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_buf_roi_rd_sched_if.sv
// Line read command channel from the ROI read scheduler to the back-buffer read engine.
// valid/addr/len/id are held by the master until valid & ready.
interface frame_buf_roi_rd_sched_if #(
  parameter int ADDR_WD = 19,
  parameter int GEO_WD  = 16
);
  logic               valid;
  logic               ready;
  logic [ADDR_WD-1:0] addr;
  logic [GEO_WD-1:0]  len;
  logic [2:0]         id;

  modport master (
    output valid,
    output addr,
    output len,
    output id,
    input  ready
  );

  modport slave (
    input  valid,
    input  addr,
    input  len,
    input  id,
    output ready
  );
endinterface

// File: rtl/frame_buf_roi_rd_sched.sv
// Multi-ROI back-buffer read scheduler: one line command per ROI line per frame.
// Optional FRAME_BUF_SCHED_STAT_EN adds ov_drop_cnt (ignored frame starts).
module frame_buf_roi_rd_sched #(
  parameter int ROI_NUM = 4,
  parameter int ADDR_WD = 19,
  parameter int GEO_WD  = 16,
  parameter int REG_WD  = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_frame_start,
  input  logic [ROI_NUM-1:0]        iv_roi_en,
  input  logic [ROI_NUM*GEO_WD-1:0] iv_roi_offset_x,
  input  logic [ROI_NUM*GEO_WD-1:0] iv_roi_offset_y,
  input  logic [ROI_NUM*GEO_WD-1:0] iv_roi_width,
  input  logic [ROI_NUM*GEO_WD-1:0] iv_roi_height,
  input  logic [ADDR_WD-1:0]        iv_frame_base,
  input  logic [GEO_WD-1:0]         iv_line_pitch,
  frame_buf_roi_rd_sched_if.master  rd,
  output logic                      o_roi_start,
  output logic                      o_roi_done,
  output logic                      o_frame_done,
`ifdef FRAME_BUF_SCHED_STAT_EN
  output logic [15:0]               ov_drop_cnt,
`endif
  output logic                      o_busy
);

  localparam int MW = (REG_WD > 2*GEO_WD) ? REG_WD : 2*GEO_WD;
  localparam int SW = MW + ADDR_WD + 1;

  typedef enum logic [2:0] {
    IDLE, LATCH, SCAN, CALC, CMD, DONE
  } state_t;

  state_t state_q;

  logic [ROI_NUM-1:0] en_q;
  logic [GEO_WD-1:0]  ox_q [ROI_NUM];
  logic [GEO_WD-1:0]  oy_q [ROI_NUM];
  logic [GEO_WD-1:0]  w_q  [ROI_NUM];
  logic [GEO_WD-1:0]  h_q  [ROI_NUM];
  logic [ADDR_WD-1:0] base_q;
  logic [GEO_WD-1:0]  pitch_q;

  logic [2:0]         roi_idx_q;
  logic [GEO_WD-1:0]  line_q;
  logic [GEO_WD-1:0]  cur_ox_q, cur_oy_q;
  logic [GEO_WD-1:0]  cur_w_q, cur_h_q;

  logic               valid_q;
  logic [ADDR_WD-1:0] addr_q;
  logic [GEO_WD-1:0]  len_q;
  logic [2:0]         id_q;
  logic               roi_start_q, roi_done_q, frame_done_q, busy_q;

  logic               hit_d;
  logic [2:0]         hit_idx_d;
  logic [GEO_WD-1:0]  hit_ox_d, hit_oy_d, hit_w_d, hit_h_d;
  logic [SW-1:0]      sum_d;
  logic [ADDR_WD-1:0] calc_addr_d;
  logic               last_line_d;

  // Descending walk so the lowest eligible index at or above roi_idx wins.
  always_comb begin
    hit_d     = 1'b0;
    hit_idx_d = '0;
    hit_ox_d  = '0;
    hit_oy_d  = '0;
    hit_w_d   = '0;
    hit_h_d   = '0;
    for (int k = ROI_NUM-1; k >= 0; k--) begin
      if (3'(k) >= roi_idx_q && en_q[k] &&
          w_q[k] != '0 && h_q[k] != '0) begin
        hit_d     = 1'b1;
        hit_idx_d = 3'(k);
        hit_ox_d  = ox_q[k];
        hit_oy_d  = oy_q[k];
        hit_w_d   = w_q[k];
        hit_h_d   = h_q[k];
      end
    end
  end

  always_comb begin
    sum_d = SW'(cur_oy_q) * SW'(pitch_q)
          + SW'(base_q) + SW'(cur_ox_q);
    calc_addr_d = ADDR_WD'(sum_d);
    last_line_d = (line_q == cur_h_q - GEO_WD'(1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      en_q         <= '0;
      base_q       <= '0;
      pitch_q      <= '0;
      for (int k = 0; k < ROI_NUM; k++) begin
        ox_q[k] <= '0;
        oy_q[k] <= '0;
        w_q[k]  <= '0;
        h_q[k]  <= '0;
      end
      roi_idx_q    <= '0;
      line_q       <= '0;
      cur_ox_q     <= '0;
      cur_oy_q     <= '0;
      cur_w_q      <= '0;
      cur_h_q      <= '0;
      valid_q      <= 1'b0;
      addr_q       <= '0;
      len_q        <= '0;
      id_q         <= '0;
      roi_start_q  <= 1'b0;
      roi_done_q   <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      roi_start_q  <= 1'b0;
      roi_done_q   <= 1'b0;
      frame_done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (i_frame_start) begin
            en_q    <= iv_roi_en;
            base_q  <= iv_frame_base;
            pitch_q <= iv_line_pitch;
            for (int k = 0; k < ROI_NUM; k++) begin
              ox_q[k] <= iv_roi_offset_x[k*GEO_WD +: GEO_WD];
              oy_q[k] <= iv_roi_offset_y[k*GEO_WD +: GEO_WD];
              w_q[k]  <= iv_roi_width[k*GEO_WD +: GEO_WD];
              h_q[k]  <= iv_roi_height[k*GEO_WD +: GEO_WD];
            end
            roi_idx_q <= '0;
            busy_q    <= 1'b1;
            state_q   <= LATCH;
          end
        end
        LATCH: state_q <= SCAN;
        SCAN: begin
          if (hit_d) begin
            roi_idx_q <= hit_idx_d;
            line_q    <= '0;
            cur_ox_q  <= hit_ox_d;
            cur_oy_q  <= hit_oy_d;
            cur_w_q   <= hit_w_d;
            cur_h_q   <= hit_h_d;
            state_q   <= CALC;
          end else begin
            frame_done_q <= 1'b1;
            state_q      <= DONE;
          end
        end
        CALC: begin
          addr_q      <= calc_addr_d;
          len_q       <= cur_w_q;
          id_q        <= roi_idx_q;
          valid_q     <= 1'b1;
          roi_start_q <= 1'b1;
          state_q     <= CMD;
        end
        CMD: begin
          if (rd.ready) begin
            if (last_line_d) begin
              valid_q    <= 1'b0;
              roi_done_q <= 1'b1;
              if (roi_idx_q == 3'(ROI_NUM-1)) begin
                frame_done_q <= 1'b1;
                state_q      <= DONE;
              end else begin
                roi_idx_q <= roi_idx_q + 3'd1;
                state_q   <= SCAN;
              end
            end else begin
              line_q <= line_q + GEO_WD'(1);
              addr_q <= addr_q + ADDR_WD'(pitch_q);
            end
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef FRAME_BUF_SCHED_STAT_EN
  logic [15:0] drop_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_q <= '0;
    end else if (i_frame_start && state_q != IDLE &&
                 drop_q != 16'hFFFF) begin
      drop_q <= drop_q + 16'd1;
    end
  end

  assign ov_drop_cnt = drop_q;
`endif

  assign rd.valid     = valid_q;
  assign rd.addr      = addr_q;
  assign rd.len       = len_q;
  assign rd.id        = id_q;
  assign o_roi_start  = roi_start_q;
  assign o_roi_done   = roi_done_q;
  assign o_frame_done = frame_done_q;
  assign o_busy       = busy_q;

endmodule

// File: tb/tb_frame_buf_roi_rd_sched.sv
// Directed bench for frame_buf_roi_rd_sched with a command scoreboard.
// Honors FRAME_BUF_SCHED_STAT_EN when defined.
module tb_frame_buf_roi_rd_sched;

  localparam int RN = 4;
  localparam int AW = 19;
  localparam int GW = 16;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [GW-1:0] len;
    logic [2:0]    id;
  } cmd_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [RN-1:0]    en;
  logic [RN*GW-1:0] vx, vy, vw, vh;
  logic [AW-1:0]    base;
  logic [GW-1:0]    pitch;
  logic             roi_start, roi_done, frame_done, busy;
`ifdef FRAME_BUF_SCHED_STAT_EN
  logic [15:0]      drop;
`endif

  frame_buf_roi_rd_sched_if #(.ADDR_WD(AW), .GEO_WD(GW)) bus ();

  frame_buf_roi_rd_sched #(
    .ROI_NUM(RN), .ADDR_WD(AW), .GEO_WD(GW), .REG_WD(32)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .i_frame_start   (start),
    .iv_roi_en       (en),
    .iv_roi_offset_x (vx),
    .iv_roi_offset_y (vy),
    .iv_roi_width    (vw),
    .iv_roi_height   (vh),
    .iv_frame_base   (base),
    .iv_line_pitch   (pitch),
    .rd              (bus),
    .o_roi_start     (roi_start),
    .o_roi_done      (roi_done),
    .o_frame_done    (frame_done),
`ifdef FRAME_BUF_SCHED_STAT_EN
    .ov_drop_cnt     (drop),
`endif
    .o_busy          (busy)
  );

  always #5 clk = ~clk;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   since = 0;
  int   first_lat, done_lat;
  int   n_acc, n_rs, n_rd, n_fd;
  bit   seen_v, stall_p, bp;
  cmd_t hold;
  cmd_t q[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_cnt();
    n_acc = 0; n_rs = 0; n_rd = 0; n_fd = 0;
    seen_v = 0; first_lat = -1; done_lat = -1;
  endtask

  // Sample at negedge, then drive at posedge+2.
  task automatic tick();
    cmd_t e;
    @(negedge clk);
    if (!reset) begin
      if (stall_p) begin
        chk("hold_valid", 32'(bus.valid), 1);
        chk("hold_addr", 32'(bus.addr), 32'(hold.addr));
        chk("hold_len", 32'(bus.len), 32'(hold.len));
        chk("hold_id", 32'(bus.id), 32'(hold.id));
      end
      if (start && !busy) begin
        since = 0;
        seen_v = 0;
      end else begin
        since++;
      end
      if (bus.valid && !seen_v) begin
        seen_v = 1;
        first_lat = since;
      end
      if (frame_done) begin
        n_fd++;
        done_lat = since;
      end
      n_rs += int'(roi_start);
      n_rd += int'(roi_done);
      if (bus.valid && bus.ready) begin
        n_acc++;
        if (q.size() == 0) begin
          chk("extra_cmd", 32'(bus.addr), 32'hDEAD);
        end else begin
          e = q.pop_front();
          chk("cmd_addr", 32'(bus.addr), 32'(e.addr));
          chk("cmd_len", 32'(bus.len), 32'(e.len));
          chk("cmd_id", 32'(bus.id), 32'(e.id));
        end
      end
      stall_p = bus.valid && !bus.ready;
      hold = '{bus.addr, bus.len, bus.id};
    end else begin
      stall_p = 0;
    end
    @(posedge clk);
    #2;
    cyc++;
    if (bp) bus.ready = ((cyc % 6) < 3);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_geo();
    en = '0; vx = '0; vy = '0; vw = '0; vh = '0;
  endtask

  task automatic set_roi(input int k, input logic [GW-1:0] x,
                         input logic [GW-1:0] y, input logic [GW-1:0] w,
                         input logic [GW-1:0] h);
    vx[k*GW +: GW] = x;
    vy[k*GW +: GW] = y;
    vw[k*GW +: GW] = w;
    vh[k*GW +: GW] = h;
  endtask

  // Reference: ROIs in index order, one command per line.
  task automatic push_model();
    logic [AW-1:0] a, ox, oy, p;
    logic [GW-1:0] w, h;
    for (int k = 0; k < RN; k++) begin
      w = vw[k*GW +: GW];
      h = vh[k*GW +: GW];
      if (en[k] && w != 0 && h != 0) begin
        ox = AW'(vx[k*GW +: GW]);
        oy = AW'(vy[k*GW +: GW]);
        p  = AW'(pitch);
        a  = base + oy * p + ox;
        for (int l = 0; l < int'(h); l++) begin
          q.push_back('{a, w, 3'(k)});
          a = a + p;
        end
      end
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    while (n_fd == 0 && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(n_fd), 1);
  endtask

  initial begin
    bus.ready = 1'b1;
    bp = 0;
    clear_geo();
    base = '0;
    pitch = '0;
    ticks(3);
    reset = 1'b0;
    tick();

    chk("rst_valid", 32'(bus.valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_fdone", 32'(frame_done), 0);
    chk("rst_rstart", 32'(roi_start), 0);
    chk("rst_rdone", 32'(roi_done), 0);
    chk("rst_addr", 32'(bus.addr), 0);
    chk("rst_len", 32'(bus.len), 0);
    chk("rst_id", 32'(bus.id), 0);
`ifdef FRAME_BUF_SCHED_STAT_EN
    chk("rst_drop", 32'(drop), 0);
`endif

    // ROI0 only, back-to-back lines
    clear_geo();
    en = 4'b0001;
    set_roi(0, 2, 1, 16, 4);
    base = 0;
    pitch = 64;
    q.push_back('{19'd66, 16'd16, 3'd0});
    q.push_back('{19'd130, 16'd16, 3'd0});
    q.push_back('{19'd194, 16'd16, 3'd0});
    q.push_back('{19'd258, 16'd16, 3'd0});
    clear_cnt();
    pulse_start();
    wait_done(40, "t1_done");
    chk("t1_first_lat", 32'(first_lat), 4);
    chk("t1_done_lat", 32'(done_lat), 9);
    chk("t1_acc", 32'(n_acc), 4);
    chk("t1_rstart", 32'(n_rs), 1);
    chk("t1_rdone", 32'(n_rd), 1);
    chk("t1_q_empty", 32'(q.size()), 0);
    ticks(2);

    // ROI1 and ROI3 enabled, 0 and 2 skipped
    clear_geo();
    en = 4'b1010;
    set_roi(0, 1, 1, 5, 3);
    set_roi(1, 4, 2, 8, 2);
    set_roi(2, 7, 7, 2, 2);
    set_roi(3, 10, 5, 3, 2);
    base = 1000;
    pitch = 100;
    push_model();
    clear_cnt();
    pulse_start();
    wait_done(40, "t2_done");
    chk("t2_acc", 32'(n_acc), 4);
    chk("t2_rstart", 32'(n_rs), 2);
    chk("t2_rdone", 32'(n_rd), 2);
    chk("t2_done_lat", 32'(done_lat), 10);
    chk("t2_q_empty", 32'(q.size()), 0);
    ticks(2);

    // Backpressure on ROI2
    clear_geo();
    en = 4'b0100;
    set_roi(2, 3, 4, 12, 4);
    base = 50;
    pitch = 40;
    push_model();
    clear_cnt();
    bp = 1;
    pulse_start();
    wait_done(80, "t3_done");
    bp = 0;
    bus.ready = 1'b1;
    chk("t3_acc", 32'(n_acc), 4);
    chk("t3_rdone", 32'(n_rd), 1);
    chk("t3_q_empty", 32'(q.size()), 0);
    ticks(2);

    // Everything enabled but zero width
    clear_geo();
    en = 4'b1111;
    for (int k = 0; k < RN; k++) set_roi(k, 1, 1, 0, 3);
    clear_cnt();
    pulse_start();
    wait_done(20, "t4_done");
    chk("t4_done_lat", 32'(done_lat), 3);
    chk("t4_no_valid", 32'(seen_v), 0);
    chk("t4_acc", 32'(n_acc), 0);
    chk("t4_rstart", 32'(n_rs), 0);
    ticks(2);

    // Address wrap modulo 2^19
    clear_geo();
    en = 4'b0001;
    set_roi(0, 5, 0, 4, 2);
    base = 19'h7FFF0;
    pitch = 32;
    q.push_back('{19'h7FFF5, 16'd4, 3'd0});
    q.push_back('{19'h00015, 16'd4, 3'd0});
    clear_cnt();
    pulse_start();
    wait_done(30, "t5_done");
    chk("t5_acc", 32'(n_acc), 2);
    chk("t5_q_empty", 32'(q.size()), 0);
    ticks(2);

    // Extra start while busy is ignored
    clear_geo();
    en = 4'b0001;
    set_roi(0, 0, 0, 4, 8);
    base = 100;
    pitch = 10;
    push_model();
    clear_cnt();
    pulse_start();
    ticks(6);
    pulse_start();
    wait_done(40, "t6_done");
    chk("t6_acc", 32'(n_acc), 8);
    chk("t6_done_lat", 32'(done_lat), 13);
    chk("t6_q_empty", 32'(q.size()), 0);
`ifdef FRAME_BUF_SCHED_STAT_EN
    chk("t6_drop", 32'(drop), 1);
`endif
    ticks(6);
    chk("t6_no_rerun", 32'(n_fd), 1);
    chk("t6_idle", 32'(busy), 0);

    // Reset while in CMD
    push_model();
    clear_cnt();
    pulse_start();
    ticks(4);
    chk("t7_in_cmd", 32'(bus.valid), 1);
    reset = 1'b1;
    tick();
    chk("t7_valid_clr", 32'(bus.valid), 0);
    chk("t7_busy_clr", 32'(busy), 0);
    reset = 1'b0;
    q.delete();
    clear_cnt();
    ticks(6);
    chk("t7_no_fdone", 32'(n_fd), 0);
    chk("t7_no_rdone", 32'(n_rd), 0);
    chk("t7_no_acc", 32'(n_acc), 0);
    chk("t7_idle", 32'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
